mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Bridges the PicoRV32 native memory interface to the on-chip RAM port and a memory-mapped LED register.
- Captures each CPU request, decodes its address, and drives the RAM select, byte-enable, address and write data for exactly one cycle.
- Registers the returned read data and answers the CPU with a single-cycle mem_ready.
- Unmapped accesses complete normally with a fixed read value, and are counted and flagged.

Parameters:
- RAM_BASE, 32'h0000_0000, base byte address of the RAM window; aligned to 2**RAM_AW.
- RAM_AW, 12, RAM window byte-address width; window size is 2**RAM_AW bytes.
- LED_ADDR, 32'h8000_0000, word address of the LED register.
- LED_W, 6, number of LED bits (1..8).
- ERR_RDATA, 32'h0000_0000, read data returned for unmapped addresses.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  CPU request valid.
- mem_instr  in  1  instruction-fetch qualifier; ignored by the decode, accepted for interface completeness.
- mem_addr  in  32  CPU byte address; word-aligned by the CPU.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  byte write strobes; 4'b0000 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- ram_sel  out  1  RAM select.
- ram_wen  out  4  RAM byte write enables.
- ram_address  out  RAM_AW  RAM byte address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM combinational read data.
- leds  out  LED_W  LED register contents.
- bus_err  out  1  sticky flag: an unmapped access has occurred.
- err_count  out  8  saturating count of unmapped accesses.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - mem_ready=0, mem_rdata=0, ram_sel=0, ram_wen=0, ram_address=0, ram_wdata=0.
  - leds=0, bus_err=0, err_count=0.
  - Takes effect immediately, including mid-transaction. A pending RAM write that has not yet reached its ACCESS clock edge is dropped.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - On a rising edge with mem_valid=1: latch mem_addr, mem_wdata and mem_wstrb into internal registers, latch the decode result (RAM / LED / NONE), and go to ACCESS.
  - Otherwise stay in IDLE.
- Decode:
  - RAM when mem_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW].
  - LED when mem_addr[31:2] == LED_ADDR[31:2].
  - NONE otherwise.
  - RAM has priority if the two windows overlap.
- ACCESS (exactly 1 cycle):
  - ram_sel=1 only when decode=RAM.
  - ram_wen = latched strobe, forced to 0 when decode is not RAM.
  - ram_address = {latched addr[RAM_AW-1:2], 2'b00}.
  - ram_wdata = latched wdata.
  - The RAM write commits on the edge that ends ACCESS.
  - On that same edge:
    - mem_rdata <= ram_rdata for RAM; {zero-extend, leds} for LED; ERR_RDATA for NONE.
    - Writes also load mem_rdata with these values; the CPU ignores them.
    - mem_ready <= 1; go to RESP.
- ram_* outputs are decoded from state and latched registers; they are 0 outside ACCESS, glitch-free.
- LED write: on the ACCESS edge, if latched strobe bit0=1, leds <= latched wdata[LED_W-1:0]. Other strobe bits are ignored.
- NONE: on the ACCESS edge, bus_err <= 1 and err_count increments, saturating at 8'hFF. Writes to NONE have no other effect.
- RESP:
  - mem_ready=1 for exactly one cycle, then mem_ready <= 0 and state returns to IDLE.
  - mem_rdata holds its value until the next ACCESS edge.
- Latency:
  - mem_valid sampled on edge N -> mem_ready high during the cycle after edge N+1.
  - That is 2 cycles, with back-to-back throughput of one access per 3 cycles.
- Request acceptance:
  - mem_valid is not re-sampled during ACCESS or RESP.
  - Changes to mem_addr, mem_wdata or mem_wstrb after capture have no effect.
  - A mem_valid still high in IDLE after RESP starts a new transaction.
- Odd strobe patterns are passed to the RAM unchanged; the RAM owns their interpretation.

Test Plan:
- Write then read RAM:
  - Stimulus: write 0xA5A5_1234 to 0x0000_0010 with wstrb=4'b1111, then read 0x0000_0010.
  - Required: ram_sel=1 for one cycle per access, ram_address=12'h010, mem_ready 2 cycles after each request, readback 0xA5A5_1234.
- Byte write:
  - Stimulus: wstrb=4'b0001, wdata=0x0000_00EE to 0x0000_0010, then read.
  - Required: ram_wen=4'b0001 during ACCESS only; readback 0xA5A5_12EE.
- LED register:
  - Stimulus: write 0x0000_002A to 0x8000_0000 (wstrb=4'b0001), then read.
  - Required: leds=6'h2A after the ACCESS edge; read returns 0x0000_002A; ram_sel stays 0 throughout.
- Unmapped access:
  - Stimulus: read 0x4000_0000.
  - Required: mem_ready after 2 cycles, mem_rdata=0, bus_err=1, err_count=1, ram_sel=0.
  - Further stimulus: 300 more unmapped accesses.
  - Required: err_count saturates at 255.
- Reset mid-operation:
  - Stimulus: assert resetn=0 during ACCESS of a RAM write.
  - Required: ram_sel, mem_ready and leds drop to 0 immediately (no clock); after release, a read of that address shows the old data.
- Back-to-back requests:
  - Stimulus: keep mem_valid held high across 4 reads of consecutive words.
  - Required: exactly 4 mem_ready pulses, each 3 cycles apart, with correct data for each word.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - PicoRV32 native memory bus bundle
//
// Ports (signals):
//   mem_valid  CPU request valid
//   mem_instr  instruction-fetch qualifier
//   mem_addr   byte address, word aligned
//   mem_wdata  write data
//   mem_wstrb  byte write strobes, 4'b0000 = read
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid with mem_ready
// Modports: master = CPU side, slave = controller side.
interface mem_bus_ctrl_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - PicoRV32 bus bridge to on-chip RAM and LED register
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   cpu           PicoRV32 native bus (slave modport)
//   ram_sel       RAM select, high for the single ACCESS cycle of a RAM hit
//   ram_wen       RAM byte write enables (0 unless RAM access)
//   ram_address   RAM byte address, word aligned
//   ram_wdata     RAM write data
//   ram_rdata     RAM combinational read data
//   leds          LED register
//   bus_err       sticky unmapped-access flag
//   err_count     saturating unmapped-access count
module mem_bus_ctrl #(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] LED_ADDR  = 32'h8000_0000,
  parameter int          LED_W     = 6,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  mem_bus_ctrl_if.slave     cpu,
  output logic              ram_sel,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_address,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [LED_W-1:0]  leds,
  output logic              bus_err,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DEC_RAM  = 2'd0,
    DEC_LED  = 2'd1,
    DEC_NONE = 2'd2
  } dec_e;

  state_e            state_q, state_d;
  dec_e              dec_q, dec_d;
  logic              led_wr_q, led_wr_d;
  logic              ram_sel_q, ram_sel_d;
  logic [3:0]        ram_wen_q, ram_wen_d;
  logic [RAM_AW-1:0] ram_address_q, ram_address_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic              bus_err_q, bus_err_d;
  logic [7:0]        err_count_q, err_count_d;

  logic hit_ram;
  logic hit_led;

  assign hit_ram = (cpu.mem_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
  assign hit_led = (cpu.mem_addr[31:2] == LED_ADDR[31:2]);

  // Decode does not use the fetch qualifier or the byte-offset bits.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, cpu.mem_instr, cpu.mem_addr[1:0]};

  always_comb begin
    state_d       = state_q;
    dec_d         = dec_q;
    led_wr_d      = led_wr_q;
    ram_sel_d     = ram_sel_q;
    ram_wen_d     = ram_wen_q;
    ram_address_d = ram_address_q;
    ram_wdata_d   = ram_wdata_q;
    mem_ready_d   = mem_ready_q;
    mem_rdata_d   = mem_rdata_q;
    leds_d        = leds_q;
    bus_err_d     = bus_err_q;
    err_count_d   = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu.mem_valid) begin
          state_d = ST_ACCESS;
          if (hit_ram) begin
            dec_d = DEC_RAM;
          end else if (hit_led) begin
            dec_d = DEC_LED;
          end else begin
            dec_d = DEC_NONE;
          end
          led_wr_d      = cpu.mem_wstrb[0];
          // RAM-facing outputs are registered on entry to ACCESS so they are
          // clean flop outputs for the whole cycle and never glitch.
          ram_sel_d     = hit_ram;
          ram_wen_d     = hit_ram ? cpu.mem_wstrb : 4'b0000;
          ram_address_d = {cpu.mem_addr[RAM_AW-1:2], 2'b00};
          ram_wdata_d   = cpu.mem_wdata;
        end
      end

      ST_ACCESS: begin
        state_d       = ST_RESP;
        ram_sel_d     = 1'b0;
        ram_wen_d     = 4'b0000;
        ram_address_d = '0;
        ram_wdata_d   = '0;
        mem_ready_d   = 1'b1;
        case (dec_q)
          DEC_RAM: begin
            mem_rdata_d = ram_rdata;
          end
          DEC_LED: begin
            mem_rdata_d = {{(32-LED_W){1'b0}}, leds_q};
            if (led_wr_q) begin
              leds_d = ram_wdata_q[LED_W-1:0];
            end
          end
          default: begin
            mem_rdata_d = ERR_RDATA;
            bus_err_d   = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
        endcase
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        mem_ready_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      dec_q         <= DEC_NONE;
      led_wr_q      <= 1'b0;
      ram_sel_q     <= 1'b0;
      ram_wen_q     <= 4'b0000;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= '0;
      leds_q        <= '0;
      bus_err_q     <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      dec_q         <= dec_d;
      led_wr_q      <= led_wr_d;
      ram_sel_q     <= ram_sel_d;
      ram_wen_q     <= ram_wen_d;
      ram_address_q <= ram_address_d;
      ram_wdata_q   <= ram_wdata_d;
      mem_ready_q   <= mem_ready_d;
      mem_rdata_q   <= mem_rdata_d;
      leds_q        <= leds_d;
      bus_err_q     <= bus_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign ram_sel       = ram_sel_q;
  assign ram_wen       = ram_wen_q;
  assign ram_address   = ram_address_q;
  assign ram_wdata     = ram_wdata_q;
  assign cpu.mem_ready = mem_ready_q;
  assign cpu.mem_rdata = mem_rdata_q;
  assign leds          = leds_q;
  assign bus_err       = bus_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ram_sel;
  logic [3:0]  ram_wen;
  logic [11:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [5:0]  leds;
  logic        bus_err;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu        (bus),
    .ram_sel    (ram_sel),
    .ram_wen    (ram_wen),
    .ram_address(ram_address),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .leds       (leds),
    .bus_err    (bus_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Environment RAM: combinational read, byte-enabled synchronous write.
  logic [31:0] tb_ram [0:1023];
  assign ram_rdata = tb_ram[ram_address[11:2]];
  always @(posedge clk) begin
    if (ram_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wen[b]) tb_ram[ram_address[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction level: a request seen at edge k is served one edge later,
  // and the controller is blind to mem_valid until edge k+3.
  logic [31:0] ref_mem [0:1023];
  int          m_edge = 0;
  int          m_acc_edge = -10;
  int          m_free_edge = 0;
  bit          m_pending = 0;
  bit          m_in_acc = 0;
  bit          m_ready = 0;
  int          m_dec = 2;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_strb = 0;
  logic [31:0] m_rdata = 0;
  logic [5:0]  m_leds = 0;
  bit          m_bus_err = 0;
  int          m_err = 0;

  function automatic int decode(input logic [31:0] a);
    if ((a >> 12) == 0) return 0;
    if ((a >> 2) == (32'h8000_0000 >> 2)) return 1;
    return 2;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pending = 0; m_in_acc = 0; m_ready = 0; m_free_edge = 0; m_acc_edge = -10;
      m_rdata = 0; m_leds = 0; m_bus_err = 0; m_err = 0;
    end else begin
      m_edge++;
      m_ready = 0;
      if (m_pending && m_edge == m_acc_edge + 1) begin
        m_pending = 0;
        m_ready = 1;
        case (m_dec)
          0: begin
            m_rdata = ref_mem[m_addr[11:2]];
            for (int b = 0; b < 4; b++)
              if (m_strb[b]) ref_mem[m_addr[11:2]][8*b +: 8] = m_wdata[8*b +: 8];
          end
          1: begin
            m_rdata = {26'd0, m_leds};
            if (m_strb[0]) m_leds = m_wdata[5:0];
          end
          default: begin
            m_rdata = 32'd0;
            m_bus_err = 1;
            if (m_err < 255) m_err++;
          end
        endcase
      end
      m_in_acc = 0;
      if (m_edge >= m_free_edge && bus.mem_valid) begin
        m_addr = bus.mem_addr; m_wdata = bus.mem_wdata; m_strb = bus.mem_wstrb;
        m_dec = decode(bus.mem_addr);
        m_acc_edge = m_edge; m_free_edge = m_edge + 3;
        m_pending = 1; m_in_acc = 1;
      end
    end
  end

  // Single compare process: every output, every cycle.
  always @(negedge clk) begin
    logic        e_sel;
    logic [3:0]  e_wen;
    logic [11:0] e_addr;
    logic [31:0] e_wd;
    e_sel  = m_in_acc && m_dec == 0;
    e_wen  = e_sel ? m_strb : 4'd0;
    e_addr = m_in_acc ? {m_addr[11:2], 2'b00} : 12'd0;
    e_wd   = m_in_acc ? m_wdata : 32'd0;
    check("ram_sel", 32'(ram_sel), 32'(e_sel));
    check("ram_wen", 32'(ram_wen), 32'(e_wen));
    check("ram_address", 32'(ram_address), 32'(e_addr));
    check("ram_wdata", ram_wdata, e_wd);
    check("mem_ready", 32'(bus.mem_ready), 32'(m_ready));
    check("mem_rdata", bus.mem_rdata, m_rdata);
    check("leds", 32'(leds), 32'(m_leds));
    check("bus_err", 32'(bus_err), 32'(m_bus_err));
    check("err_count", 32'(err_count), 32'(m_err));
  end

  // ---------------- stimulus ----------------
  // Called #1 after a rising edge with the DUT idle; returns after RESP.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r, output int lat);
    bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    bus.mem_instr = 1'($urandom_range(0, 1)); bus.mem_valid = 1'b1;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    bus.mem_addr = $urandom; bus.mem_wdata = $urandom; bus.mem_wstrb = 4'($urandom);
    lat = 1;
    while (!bus.mem_ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.mem_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got no mem_ready expected within 2 cycles");
    end
    r = bus.mem_rdata;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_none_addr();
    logic [31:0] v;
    v = $urandom;
    return {2'b01, v[29:2], 2'b00};
  endfunction

  initial begin
    logic [31:0] r;
    logic [31:0] bb_w [4];
    int lat, npulse, cyc, last_cyc;

    for (int i = 0; i < 1024; i++) begin tb_ram[i] = 0; ref_mem[i] = 0; end
    bus.mem_valid = 0; bus.mem_instr = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    check("rst_ram_sel", 32'(ram_sel), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Write then read RAM
    access(32'h0000_0010, 32'hA5A5_1234, 4'b1111, r, lat);
    check("wr_latency", 32'(lat), 32'd2);
    access(32'h0000_0010, 32'h0, 4'b0000, r, lat);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_a5a51234", r, 32'hA5A5_1234);

    // Byte write
    access(32'h0000_0010, 32'h0000_00EE, 4'b0001, r, lat);
    access(32'h0000_0010, 32'h0, 4'b0000, r, lat);
    check("byte_rd", r, 32'hA5A5_12EE);

    // LED register
    access(32'h8000_0000, 32'h0000_002A, 4'b0001, r, lat);
    check("led_val", 32'(leds), 32'h2A);
    access(32'h8000_0000, 32'h0, 4'b0000, r, lat);
    check("led_rd", r, 32'h0000_002A);

    // Randomized mix, checked by the model
    for (int n = 0; n < 150; n++) begin
      int sel;
      logic [31:0] a;
      logic [3:0]  s;
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 32'($urandom_range(0, 63)) << 2;
      else if (sel < 8) a = 32'h8000_0000;
      else              a = rand_none_addr();
      s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      access(a, $urandom, s, r, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset during ACCESS of a RAM write
    access(32'h0000_0020, 32'h1111_2222, 4'b1111, r, lat);
    access(32'h8000_0000, 32'h0000_0015, 4'b0001, r, lat);
    check("led_pre_rst", 32'(leds), 32'h15);
    bus.mem_addr = 32'h0000_0020; bus.mem_wdata = 32'hDEAD_BEEF; bus.mem_wstrb = 4'b1111;
    bus.mem_valid = 1'b1;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    check("acc_sel_pre_rst", 32'(ram_sel), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("rst_async_sel", 32'(ram_sel), 32'd0);
    check("rst_async_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_async_leds", 32'(leds), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    access(32'h0000_0020, 32'h0, 4'b0000, r, lat);
    check("rst_old_data", r, 32'h1111_2222);

    // Unmapped access and saturation
    access(32'h4000_0000, 32'h0, 4'b0000, r, lat);
    check("none_latency", 32'(lat), 32'd2);
    check("none_rdata", r, 32'd0);
    check("none_bus_err", 32'(bus_err), 32'd1);
    check("none_err1", 32'(err_count), 32'd1);
    for (int n = 0; n < 300; n++) access(rand_none_addr(), $urandom, 4'($urandom), r, lat);
    check("none_sat", 32'(err_count), 32'd255);

    // Back-to-back with mem_valid held high
    for (int i = 0; i < 4; i++) begin
      bb_w[i] = $urandom;
      access(32'h0000_0100 + 32'(i * 4), bb_w[i], 4'b1111, r, lat);
    end
    bus.mem_addr = 32'h0000_0100; bus.mem_wstrb = 4'b0000; bus.mem_valid = 1'b1;
    npulse = 0; cyc = 0; last_cyc = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.mem_ready) begin
        check("b2b_data", bus.mem_rdata, bb_w[npulse & 3]);
        if (npulse > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        npulse++;
        if (npulse < 4) bus.mem_addr = 32'h0000_0100 + 32'(npulse * 4);
        else bus.mem_valid = 1'b0;
      end
    end
    check("b2b_pulses", 32'(npulse), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
